rr_hold_arb: RTL
================

RR_HOLD_ARB -- requirements
Module: rr_hold_arb

Interface
REQ-001 Parameter N, default 4, number of requesters; legal range 2..16.
REQ-002 Parameter MAXHOLD, default 0, maximum consecutive grant cycles before forced release; 0 means unlimited hold; legal range 0..255.
REQ-003 Parameter IDXW, default $clog2(N), width of the binary select index.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_  input  1  reset, asynchronous assert, active-low (`Enable_` level).
REQ-006 req  input  N  per-requester request, level-sensitive.
REQ-007 grt  output  N  grant for the current cycle, combinational, one-hot or zero.
REQ-008 sel  output  N  registered copy of the previous cycle's grt, one-hot or zero.
REQ-009 sel_idx  output  IDXW  binary index of the set bit of sel; 0 when sel is zero.
REQ-010 sel_vld  output  1  high when sel is nonzero.

Function
REQ-011 State: last (N bits), ptr (IDXW bits, round-robin start index), hcnt (width $clog2(MAXHOLD+1), minimum 1).
REQ-012 hold = last & req; other = req & ~last.
REQ-013 expired = (MAXHOLD != 0) && (hcnt == MAXHOLD) && (other != 0).
REQ-014 If hold != 0 and not expired, grt = hold (holder keeps the grant, zero extra latency).
REQ-015 If hold != 0 and expired, grt = round-robin pick over other.
REQ-016 If hold == 0, grt = round-robin pick over req.
REQ-017 Round-robin pick: first set bit scanning indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1; zero if the candidate vector is zero.
REQ-018 grt never has more than one bit set; grt bit i implies req bit i.
REQ-019 Every cycle: last <= grt.
REQ-020 When grt != 0 and grt != last, ptr <= (index of grt + 1) mod N; otherwise ptr unchanged.
REQ-021 hcnt: grt == 0 -> 0; grt != 0 and grt != last -> 1; grt == last != 0 -> hcnt+1, saturating at MAXHOLD (saturate at counter max when MAXHOLD = 0).
REQ-022 Lone holder (other == 0) is never preempted, even with hcnt == MAXHOLD.
REQ-023 Requester dropping req releases immediately: grt moves to the RR pick in the same cycle.
REQ-024 sel = last; sel_idx = encode(last); sel_vld = |last.
REQ-025 No combinational path from sel/sel_idx/sel_vld to req; grt depends only on req and state.
REQ-026 With N=2, MAXHOLD=0 the grant sequence is identical to a hold-until-drop arbiter with RR tie-break.

Reset
REQ-027 On rst_ low, asynchronously: last = 0, ptr = 0, hcnt = 0.
REQ-028 During reset sel = 0, sel_idx = 0, sel_vld = 0; grt still evaluates combinationally from req with ptr = 0 and no holder.
REQ-029 Reset asserted mid-hold drops the hold; first cycle after release arbitrates fresh from index 0.

Verification (N=4, MAXHOLD=3 unless stated)
REQ-030 After reset, req=4'b1010 -> grt=4'b0010; next cycle sel=4'b0010, sel_idx=1, sel_vld=1, ptr=2.
REQ-031 Hold and timeout: req=4'b0011 held 6 cycles -> grt 0001,0001,0001,0010,0010,0010; sel trails grt by one cycle.
REQ-032 Lone holder: req=4'b0100 for 10 cycles -> grt=4'b0100 every cycle, hcnt saturates at 3, no gap.
REQ-033 Fairness: req=4'b1111 with each holder dropping req after 1 grant cycle -> grants rotate 0001,0010,0100,1000,0001.
REQ-034 MAXHOLD=0: req=4'b1001 for 20 cycles -> grt=4'b0001 throughout; drop req[0] -> grt=4'b1000 same cycle.
REQ-035 Async reset mid-hold (grt=0100, hcnt=2): rst_ low between edges -> sel=0, sel_vld=0 immediately; after release with req=4'b0110 -> grt=4'b0010.

Source files
------------

// File: rtl/rr_hold_arb.sv
// rr_hold_arb: round-robin arbiter where the current holder keeps the grant
// while it requests. If MAXHOLD is nonzero, a holder that has had MAXHOLD
// consecutive cycles is forced to release when another requester is waiting.
module rr_hold_arb #(
   parameter int unsigned N       = 4,
   parameter int unsigned MAXHOLD = 0,
   parameter int unsigned IDXW    = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    grt,
   output logic [N-1:0]    sel,
   output logic [IDXW-1:0] sel_idx,
   output logic            sel_vld
);

   localparam int unsigned HCW = (MAXHOLD == 0) ? 1 : $clog2(MAXHOLD + 1);
   localparam logic [HCW-1:0] HSAT = (MAXHOLD == 0) ? {HCW{1'b1}} : HCW'(MAXHOLD);

   logic [N-1:0]    last_q;
   logic [IDXW-1:0] ptr_q;
   logic [HCW-1:0]  hcnt_q;
   logic [IDXW-1:0] sel_idx_q;
   logic            sel_vld_q;

   logic [N-1:0]    hold;
   logic [N-1:0]    other;
   logic            expired;
   logic            new_grant;
   logic [IDXW-1:0] gidx;
   logic [IDXW-1:0] ptr_nxt;
   logic [HCW-1:0]  hcnt_nxt;

   // First set bit of cand, scanning from index p upward with wraparound.
   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] cand,
                                            input logic [IDXW-1:0] p);
      logic [2*N-1:0] dbl;
      logic [N-1:0]   pick;
      logic           found;
      int             pos;
      dbl   = {cand, cand} >> p;
      pick  = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < int'(N); k++) begin
         if (!found && dbl[k]) begin
            found = 1'b1;
            pos   = int'(p) + k;
            if (pos >= int'(N)) pos = pos - int'(N);
            pick  = N'(1) << pos;
         end
      end
      return pick;
   endfunction

   // Binary index of the set bit of a one-hot vector; 0 when empty.
   function automatic logic [IDXW-1:0] enc(input logic [N-1:0] v);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (v[i]) idx = IDXW'(i);
      end
      return enc_ret(idx);
   endfunction

   function automatic logic [IDXW-1:0] enc_ret(input logic [IDXW-1:0] x);
      return x;
   endfunction

   // Grant selection: keep the holder unless its hold budget is spent and someone waits.
   always_comb begin
      hold    = last_q & req;
      other   = req & ~last_q;
      expired = (MAXHOLD != 0) && (hcnt_q == HSAT) && (|other);
      grt     = '0;
      if (|hold) begin
         if (expired) grt = rr_pick(other, ptr_q);
         else         grt = hold;
      end else begin
         grt = rr_pick(req, ptr_q);
      end
   end

   // Next pointer and hold counter derived from this cycle's grant.
   always_comb begin
      new_grant = (|grt) && (grt != last_q);
      gidx      = enc(grt);
      ptr_nxt   = ptr_q;
      hcnt_nxt  = hcnt_q;
      if (new_grant) begin
         ptr_nxt = (gidx == IDXW'(N - 1)) ? '0 : gidx + IDXW'(1);
      end
      if (!(|grt))        hcnt_nxt = '0;
      else if (new_grant) hcnt_nxt = HCW'(1);
      else if (hcnt_q != HSAT) hcnt_nxt = hcnt_q + HCW'(1);
   end

   // Arbitration state and registered select outputs.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         last_q    <= '0;
         ptr_q     <= '0;
         hcnt_q    <= '0;
         sel_idx_q <= '0;
         sel_vld_q <= 1'b0;
      end else begin
         last_q    <= grt;
         ptr_q     <= ptr_nxt;
         hcnt_q    <= hcnt_nxt;
         sel_idx_q <= gidx;
         sel_vld_q <= |grt;
      end
   end

   assign sel     = last_q;
   assign sel_idx = sel_idx_q;
   assign sel_vld = sel_vld_q;

endmodule
